// File: rtl/mcc_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle, with a fast path for divide-by-zero and signed overflow.
module mcc_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc, acc_step;
    logic              neg_q, rem_neg_q;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic              div_zero, div_ovf, fast, accept;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     add_sum, trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // Operand decode at issue time; op[2] selects divide, op[0] unsigned divide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (op[2]) begin
            a_signed = ~op[0];
            b_signed = ~op[0];
        end else begin
            a_signed = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
            b_signed = (op[1:0] == 2'b01);
        end
        sign_a   = a_signed & src_a[XLEN-1];
        sign_b   = b_signed & src_b[XLEN-1];
        mag_a    = sign_a ? -src_a : src_a;
        mag_b    = sign_b ? -src_b : src_b;
        div_zero = op[2] && (src_b == '0);
        div_ovf  = op[2] && !op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);
        fast     = div_zero | div_ovf;
        accept   = start && !kill;
    end

    // One iteration: acc = {hi, lo}; multiply adds b_q into hi and shifts right,
    // divide shifts left and subtracts b_q when the trial remainder is non-negative.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, b_q};
        acc_step = {add_sum, acc[XLEN-1:1]};
        if (op_q[2]) begin
            if (trial[XLEN])
                acc_step = {acc[2*XLEN-2:0], 1'b0};
            else
                acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (op_q[2])
            fix_res = op_q[1] ? rem : quo;
        else
            fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_nxt = fast ? S_FIX : S_CALC;
                else
                    state_nxt = S_IDLE;
            end
            S_CALC: begin
                if (kill)
                    state_nxt = S_IDLE;
                else if (cnt == '0)
                    state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = kill ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_CALC) || (state_nxt == S_FIX);
            done  <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_q      <= '0;
            b_q       <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q <= op;
                        cnt  <= CW'(XLEN-1);
                        b_q  <= mag_b;
                        if (fast) begin
                            // Preload so FIX picks the answer: quotient low, remainder high.
                            acc       <= div_zero ? {src_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, src_a};
                            neg_q     <= 1'b0;
                            rem_neg_q <= 1'b0;
                        end else begin
                            acc       <= {{XLEN{1'b0}}, mag_a};
                            neg_q     <= sign_a ^ sign_b;
                            rem_neg_q <= sign_a;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    if (!kill)
                        result <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcc_muldiv.sv
// Directed testbench for mcc_muldiv: timing, RV32M results, fast path, kill,
// reset and back-to-back issue, plus an XLEN = 8 instance.
module tb_mcc_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, kill;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] result;

    logic        start8, kill8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  result8;

    int n_pass = 0;
    int n_chk  = 0;

    int          done_cnt, busy_cnt, busy_first, busy_last;
    int          done_cyc [4];
    logic [31:0] done_res [4];

    always #5 clk = ~clk;

    mcc_muldiv #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
        .src_b(src_b), .kill(kill), .busy(busy), .done(done), .result(result)
    );

    mcc_muldiv #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .src_a(a8),
        .src_b(b8), .kill(kill8), .busy(busy8), .done(done8), .result(result8)
    );

    // Issue at cycle 0, then observe cycles 1..ncyc on falling edges. Operands are
    // scrambled after issue; an optional second start and a kill can be injected.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int restart_at, input logic [2:0] o2, input logic [31:0] a2,
                          input logic [31:0] b2, input int kill_at, input int ncyc);
        done_cnt = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1; kill = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (done) begin
                if (done_cnt < 4) begin
                    done_cyc[done_cnt] = c;
                    done_res[done_cnt] = result;
                end
                done_cnt++;
            end
            start = (c == restart_at);
            kill  = (c == kill_at);
            if (c == restart_at) begin
                op = o2; src_a = a2; src_b = b2;
            end else begin
                op = o ^ 3'b111; src_a = ~a; src_b = ~b;
            end
        end
        start = 1'b0; kill = 1'b0;
    endtask

    task automatic run_simple(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        run_op(o, a, b, -1, 3'b000, 32'h0, 32'h0, -1, 38);
    endtask

    task automatic test_reset;
        n_chk++;
        if ({busy, done, result} !== 34'h0) $display("FAIL reset_outputs: got %h expected 0", {busy, done, result});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, done, result} !== 34'h0) $display("FAIL post_reset_idle: got %h expected 0", {busy, done, result});
        else n_pass++;
    endtask

    task automatic test_mul_timing;
        run_simple(3'b000, 32'd7, 32'hFFFF_FFFD);
        n_chk++;
        if (done_cnt !== 1 || done_cyc[0] !== 34) $display("FAIL mul_done_timing: got cnt=%0d cyc=%0d expected 1/34", done_cnt, done_cyc[0]);
        else n_pass++;
        n_chk++;
        if (done_res[0] !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h expected ffffffeb", done_res[0]);
        else n_pass++;
        n_chk++;
        if (busy_first !== 1 || busy_last !== 33 || busy_cnt !== 33)
            $display("FAIL mul_busy_window: got %0d..%0d (%0d) expected 1..33 (33)", busy_first, busy_last, busy_cnt);
        else n_pass++;
    endtask

    task automatic test_mul_high;
        logic [2:0]  ops [3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        for (int i = 0; i < 3; i++) begin
            run_simple(ops[i], as[i], bs[i]);
            n_chk++;
            if (done_cnt !== 1 || done_res[0] !== exp[i])
                $display("FAIL mul_high op=%0d: got %h (done %0d) expected %h", ops[i], done_res[0], done_cnt, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_simple(ops[i], as[i], bs[i]);
            n_chk++;
            if (done_cnt !== 1 || done_cyc[0] !== 34 || done_res[0] !== exp[i])
                $display("FAIL div op=%0d: got %h at cycle %0d expected %h at 34", ops[i], done_res[0], done_cyc[0], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fast_path;
        logic [2:0]  ops [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            run_simple(ops[i], as[i], bs[i]);
            n_chk++;
            if (done_cnt !== 1 || done_cyc[0] !== 2 || done_res[0] !== exp[i] || busy_cnt !== 1)
                $display("FAIL fast_path op=%0d: got %h at cycle %0d busy %0d expected %h at 2 busy 1",
                         ops[i], done_res[0], done_cyc[0], busy_cnt, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_start;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 10, 3'b101, 32'd100, 32'd7, -1, 40);
        n_chk++;
        if (done_cnt !== 1 || done_cyc[0] !== 34 || done_res[0] !== 32'hFFFF_FFEB)
            $display("FAIL ignored_start: got cnt=%0d cyc=%0d res=%h expected 1/34/ffffffeb", done_cnt, done_cyc[0], done_res[0]);
        else n_pass++;
    endtask

    task automatic test_kill;
        run_simple(3'b111, 32'd100, 32'd7);
        run_op(3'b000, 32'd3, 32'd3, -1, 3'b000, 32'h0, 32'h0, 12, 40);
        n_chk++;
        if (done_cnt !== 0) $display("FAIL kill_no_done: got %0d dones expected 0", done_cnt);
        else n_pass++;
        n_chk++;
        if (busy_last !== 12) $display("FAIL kill_to_idle: got last busy cycle %0d expected 12", busy_last);
        else n_pass++;
        n_chk++;
        if (result !== 32'd2) $display("FAIL kill_result_hold: got %h expected 2", result);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        run_op(3'b101, 32'd100, 32'd7, 34, 3'b111, 32'd100, 32'd7, -1, 72);
        n_chk++;
        if (done_cnt !== 2 || done_cyc[0] !== 34 || done_cyc[1] !== 68)
            $display("FAIL b2b_timing: got cnt=%0d cyc=%0d,%0d expected 2 at 34,68", done_cnt, done_cyc[0], done_cyc[1]);
        else n_pass++;
        n_chk++;
        if (done_res[0] !== 32'd14 || done_res[1] !== 32'd2)
            $display("FAIL b2b_results: got %h,%h expected e,2", done_res[0], done_res[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int ndone;
        @(negedge clk);
        op = 3'b000; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || result === 32'h0) $display("FAIL pre_reset_busy: got busy=%b result=%h expected busy 1, result nonzero", busy, result);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, result} !== 34'h0) $display("FAIL reset_mid_calc: got %h expected 0", {busy, done, result});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_chk++;
        if (ndone !== 0) $display("FAIL reset_discard: got %0d active cycles expected 0", ndone);
        else n_pass++;
    endtask

    task automatic test_xlen8;
        int cyc, cnt;
        logic [7:0] res;
        cyc = -1; cnt = 0; res = 8'h0;
        @(negedge clk);
        op8 = 3'b011; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
            if (done8) begin
                cnt++; cyc = c; res = result8;
            end
        end
        n_chk++;
        if (cnt !== 1 || cyc !== 10) $display("FAIL x8_timing: got cnt=%0d cyc=%0d expected 1/10", cnt, cyc);
        else n_pass++;
        n_chk++;
        if (res !== 8'hFE) $display("FAIL x8_mulhu: got %h expected fe", res);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
        start8 = 1'b0; kill8 = 1'b0; op8 = 3'b000; a8 = '0; b8 = '0;
        #12;
        test_reset;
        test_mul_timing;
        test_mul_high;
        test_div;
        test_fast_path;
        test_ignored_start;
        test_kill;
        test_back_to_back;
        test_reset_mid;
        test_xlen8;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mcc_muldiv.md
# mcc_muldiv

Iterative multiply/divide unit implementing the RV32M operation set, parametrised in operand width. It sits beside the multi-cycle core's single-cycle ALU: the core's EXECUTE state issues `start` for OP_ALU_RD instructions with funct7 = 0000001, stalls until `done`, then writes `result` in its WRITE state. It uses one shift-add or restoring-divide step per cycle, with a fast path for divide special cases.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Must be ≥ 4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only when not busy.
- `op`  in  3  RV32M funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `src_a`  in  XLEN  rs1 operand; multiplicand or dividend.
- `src_b`  in  XLEN  rs2 operand; multiplier or divisor.
- `kill`  in  1  synchronous abort of the operation in flight.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  registered result, held until the next completion.

## Operation
- States:
  - IDLE
  - CALC: iteration counter runs XLEN-1 down to 0.
  - FIX: sign correction and result select.
  - DONE: asserts `done`.
- Capture:
  - `start` in IDLE or DONE latches `op`, the operand magnitudes and the sign flags.
  - Later changes on `src_a`, `src_b` or `op` have no effect on the operation in flight.
- Signedness:
  - Signed: MULH, DIV and REM treat both operands as signed; MULHSU treats only `src_a` as signed.
  - Unsigned: MUL, MULHU, DIVU and REMU treat both operands as unsigned. MUL's low half is identical either way.
- Multiply:
  - 2·XLEN-bit accumulator, one conditional add-and-shift per CALC cycle.
  - In FIX, negate the 2·XLEN product if the operand signs differ.
  - MUL returns bits [XLEN-1:0]; MULH, MULHSU and MULHU return bits [2·XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - In FIX, the quotient is negated when the signs differ (DIV). The remainder takes the sign of the dividend (REM).
- Fast path: IDLE/DONE goes directly to FIX, skipping CALC, for these cases:
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → `src_a`.
  - Signed overflow (DIV/REM, `src_a` = 1 followed by XLEN-1 zeros, `src_b` = all ones): DIV → `src_a`; REM → 0.
- `kill`:
  - In CALC or FIX, the next edge goes to IDLE.
  - No `done`; `result` is unchanged.
  - `kill` overrides a simultaneous `start`. `kill` in IDLE or DONE has no effect, apart from that override.
- `start` while `busy` is ignored. There is no queueing.

## Timing
- Reset (async, while `rst_n` = 0): state IDLE, `busy` = 0, `done` = 0, `result` = 0, counter = 0.
  - Reset mid-operation discards the operation with no `done`.
- Normal path, with `start` sampled at the end of cycle 0:
  - Cycles 1..XLEN: CALC.
  - Cycle XLEN+1: FIX.
  - Cycle XLEN+2: DONE, `done` = 1. For XLEN = 32, `done` is in cycle 34.
- Fast path: cycle 1 FIX, cycle 2 `done`.
- `busy`:
  - High exactly in CALC and FIX: cycles 1..XLEN+1, or cycle 1 on the fast path.
  - Low in IDLE and DONE.
- Back-to-back: `start` in the DONE cycle is accepted. The next CALC begins the following cycle, giving one completion per XLEN+2 cycles.
- `result` updates only on the FIX→DONE edge.
- `done` is a registered output; there is no combinational path from inputs to outputs.

## Test plan
- MUL 7 × 0xFFFFFFFD (XLEN = 32), `start` at cycle 0 → `done` only in cycle 34, `result` 0xFFFFFFEB, `busy` high in cycles 1–33 only.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD. REM −7%2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100%7 → 2.
- Fast path:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; both with `done` in cycle 2.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both with `done` in cycle 2.
- `start` pulsed at cycle 10 during a busy operation → ignored, single `done` at cycle 34.
- `kill` at cycle 12 → IDLE at cycle 13, no `done`, `result` holds its prior value.
- Reset asserted mid-CALC → outputs 0 immediately.
- New `start` in a DONE cycle → next `done` exactly XLEN+2 cycles later.
- Re-run with XLEN = 8: MULHU 0xFF × 0xFF → 0xFE, `done` in cycle 10.
